// File: rtl/aeolus_pkg.sv
// aeolus_pkg: shared state encoding, opcode constants and width defaults for the Aeolus CPU
package aeolus_pkg;
  localparam int PC_W_DEF  = 4;
  localparam int OPC_W_DEF = 4;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_EXEC   = 2'd3
  } state_t;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_SNZA = 4'h8;
  localparam logic [3:0] OP_SNZS = 4'h9;
  localparam logic [3:0] OP_LDA  = 4'hA;
  localparam logic [3:0] OP_LDB  = 4'hB;
  localparam logic [3:0] OP_OUT  = 4'hC;
endpackage

// File: rtl/aeolus_pc_unit.sv
// aeolus_pc_unit: program counter with +1/+2 advance and carry-out of the pending increment
module aeolus_pc_unit
  import aeolus_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            adv,
  input  logic            two,
  output logic [PC_W-1:0] pc,
  output logic            carry
);
  logic [PC_W:0] sum;
  always_comb sum = {1'b0, pc} + (two ? (PC_W+1)'(2) : (PC_W+1)'(1));
  assign carry = sum[PC_W];
  always_ff @(posedge clk) begin
    if (reset) pc <= '0;
    else if (adv) pc <= sum[PC_W-1:0];
  end
endmodule

// File: rtl/aeolus_sequencer.sv
// aeolus_sequencer: fetch/decode/exec control FSM with skip and run/halt handling
// Optional single-step input enabled by AEOLUS_SINGLE_STEP_EN.
module aeolus_sequencer
  import aeolus_pkg::*;
#(
  parameter int PC_W         = PC_W_DEF,
  parameter int OPC_W        = OPC_W_DEF,
  parameter bit STOP_ON_WRAP = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
`ifdef AEOLUS_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [OPC_W-1:0] opcode,
  input  logic             skip_cond,
  output logic [PC_W-1:0]  pc,
  output logic             rom_en,
  output logic [OPC_W-1:0] ir,
  output logic             exec_en,
  output logic             skipped,
  output logic             halted,
  output logic [1:0]       state
);
  state_t st;
  logic   go, take, carry;
`ifdef AEOLUS_SINGLE_STEP_EN
  assign go = run | step;
`else
  assign go = run;
`endif
  assign rom_en  = st == S_FETCH;
  assign exec_en = st == S_EXEC;
  assign halted  = st == S_IDLE;
  assign state   = st;
  assign take    = ((ir == OPC_W'(OP_SNZA)) || (ir == OPC_W'(OP_SNZS))) && skip_cond;
  aeolus_pc_unit #(.PC_W(PC_W)) u_pc (
    .clk  (clk),
    .reset(reset),
    .adv  (exec_en),
    .two  (take),
    .pc   (pc),
    .carry(carry)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= S_IDLE;
      ir      <= '0;
      skipped <= 1'b0;
    end else begin
      skipped <= 1'b0;
      case (st)
        S_IDLE:   st <= go ? S_FETCH : S_IDLE;
        S_FETCH:  st <= S_DECODE;
        S_DECODE: begin
          ir <= opcode;
          st <= S_EXEC;
        end
        default: begin
          skipped <= take;
          st      <= ((STOP_ON_WRAP && carry) || !run) ? S_IDLE : S_FETCH;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aeolus_sequencer.sv
// tb_aeolus_sequencer: two sequencers (wrap continues / wrap halts) against an instruction-level model
module tb_aeolus_sequencer;
  logic clk = 1'b0, reset = 1'b1, run = 1'b0, skip_cond = 1'b0;
  int   stp = 0;
`ifdef AEOLUS_SINGLE_STEP_EN
  logic step = 1'b0;
`endif
  logic [3:0] rom [16];
  logic [3:0] q [2];
  logic [3:0] pc [2];
  logic [3:0] ir [2];
  logic [1:0] state [2];
  logic       rom_en [2], exec_en [2], skipped [2], halted [2];
  int ph [2], mpc [2], mir [2], msk [2];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    aeolus_sequencer #(.STOP_ON_WRAP(g == 1)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
`ifdef AEOLUS_SINGLE_STEP_EN
      .step     (step),
`endif
      .opcode   (q[g]),
      .skip_cond(skip_cond),
      .pc       (pc[g]),
      .rom_en   (rom_en[g]),
      .ir       (ir[g]),
      .exec_en  (exec_en[g]),
      .skipped  (skipped[g]),
      .halted   (halted[g]),
      .state    (state[g])
    );
    always @(posedge clk) if (rom_en[g]) q[g] <= rom[pc[g]];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Phase 0 idle, 1 fetch, 2 decode, 3 execute; ir is whatever the ROM holds at the fetched pc.
  task automatic model_edge(input int w);
    int sum;
    bit tk;
    if (reset) begin
      ph[w] = 0; mpc[w] = 0; mir[w] = 0; msk[w] = 0;
    end else if (ph[w] == 0) begin
      msk[w] = 0; ph[w] = (run || stp != 0) ? 1 : 0;
    end else if (ph[w] == 1) begin
      msk[w] = 0; ph[w] = 2;
    end else if (ph[w] == 2) begin
      msk[w] = 0; mir[w] = int'(rom[mpc[w]]); ph[w] = 3;
    end else begin
      tk = (mir[w] == 8 || mir[w] == 9) && skip_cond;
      sum = mpc[w] + (tk ? 2 : 1);
      mpc[w] = sum % 16;
      msk[w] = tk ? 1 : 0;
      ph[w] = ((w == 1 && sum >= 16) || !run) ? 0 : 1;
    end
  endtask
  task automatic check_dut(input int w);
    check($sformatf("d%0d_state", w), 32'(state[w]), 32'(ph[w]));
    check($sformatf("d%0d_pc", w), 32'(pc[w]), 32'(mpc[w]));
    check($sformatf("d%0d_ir", w), 32'(ir[w]), 32'(mir[w]));
    check($sformatf("d%0d_skipped", w), 32'(skipped[w]), 32'(msk[w]));
    check($sformatf("d%0d_rom_en", w), 32'(rom_en[w]), 32'(ph[w] == 1));
    check($sformatf("d%0d_exec_en", w), 32'(exec_en[w]), 32'(ph[w] == 3));
    check($sformatf("d%0d_halted", w), 32'(halted[w]), 32'(ph[w] == 0));
  endtask
  initial begin
    for (int i = 0; i < 16; i++) rom[i] = ($urandom % 3 == 0) ? 4'(8 + $urandom % 2) : 4'($urandom % 16);
    rom[0] = 4'h1; rom[1] = 4'h2; rom[2] = 4'h3; rom[4] = 4'h8; rom[15] = 4'h1;
    for (int w = 0; w < 2; w++) begin
      ph[w] = 0; mpc[w] = 0; mir[w] = 0; msk[w] = 0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc < 14) begin
        reset = cyc < 2; run = 1'b1; skip_cond = 1'b0;
      end else begin
        reset = $urandom % 120 == 0;
        run = cyc < 2000 ? ($urandom % 10 != 0) : ($urandom % 3 == 0);
        skip_cond = 1'($urandom % 2);
      end
`ifdef AEOLUS_SINGLE_STEP_EN
      step = cyc >= 14 && ($urandom % 5 == 0);
      stp = int'(step);
`endif
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check_dut(0);
      check_dut(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
